// File: rtl/sha256_pkg.sv
//------------------------------------------------------------------------------
// Module   : sha256_pkg
// Brief    : Constants shared by the SHA-256 schedule and compression blocks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

   localparam int WORD_W          = 32;
   localparam int NUM_ROUNDS      = 64;
   localparam int WORDS_PER_BLOCK = 16;

   // Round-state encoding seen by the compression block
   localparam logic [1:0] RS_IDLE        = 2'b00;
   localparam logic [1:0] RS_ROUND0TO15  = 2'b01;
   localparam logic [1:0] RS_ROUND16TO63 = 2'b10;
   localparam logic [1:0] RS_ROUND64     = 2'b11;

   function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_msg_sched_if.sv
//------------------------------------------------------------------------------
// Module   : sha256_msg_sched_if
// Brief    : Word-load handshake and round outputs of the message schedule.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sha256_msg_sched_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ready_out;
   logic                  load_out;
   logic [1:0]            FSM_state_out;
   logic [6:0]            round_out;
   logic [DATA_WIDTH-1:0] w_out;
   logic                  busy_out;

   modport master (
      output valid_in, data_in,
      input  ready_out, load_out, FSM_state_out, round_out, w_out, busy_out
   );

   modport slave (
      input  valid_in, data_in,
      output ready_out, load_out, FSM_state_out, round_out, w_out, busy_out
   );
endinterface

`default_nettype wire

// File: rtl/sha256_sigma.sv
//------------------------------------------------------------------------------
// Module   : sha256_sigma
// Brief    : Small-sigma function of the SHA-256 schedule (sigma0 or sigma1).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_sigma
   import sha256_pkg::*;
#(
   parameter bit SEL_SIGMA1 = 1'b0
) (
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);

   generate
      if (SEL_SIGMA1) begin : g_sigma1
         assign y = rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
      end else begin : g_sigma0
         assign y = rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/sha256_msg_sched.sv
//------------------------------------------------------------------------------
// Module   : sha256_msg_sched
// Brief    : Loads a 16-word block, then streams W0..W63 over 64 round cycles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS
) (
   input  logic                clk,
   input  logic                rst,
   sha256_msg_sched_if.slave   bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_R_LO  = 3'd2;
   localparam logic [2:0] S_R_HI  = 3'd3;
   localparam logic [2:0] S_R_FIN = 3'd4;

   localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
   localparam logic [6:0] LAST_LO   = 7'(WORDS_PER_BLOCK - 1);
   localparam logic [6:0] LAST_HI   = 7'(NUM_ROUNDS - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_next_state;
   logic [3:0]            r_word_cnt;
   logic [6:0]            r_round;
   logic [DATA_WIDTH-1:0] r_win [WORDS_PER_BLOCK];

   logic                  w_accept;
   logic                  w_rounding;
   logic [DATA_WIDTH-1:0] w_s0;
   logic [DATA_WIDTH-1:0] w_s1;
   logic [DATA_WIDTH-1:0] w_new;

   assign w_accept   = bus.valid_in && bus.ready_out;
   assign w_rounding = (r_state == S_R_LO) || (r_state == S_R_HI);

   sha256_sigma #(.SEL_SIGMA1(1'b0)) u_sigma0 (.x(r_win[1]),  .y(w_s0));
   sha256_sigma #(.SEL_SIGMA1(1'b1)) u_sigma1 (.x(r_win[14]), .y(w_s1));

   // Window entry i holds W[t+i], so this is W[t+16]
   assign w_new = w_s1 + r_win[9] + w_s0 + r_win[0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_LOAD;
         S_LOAD:  if (w_accept && (r_word_cnt == LAST_WORD)) w_next_state = S_R_LO;
         S_R_LO:  if (r_round == LAST_LO) w_next_state = S_R_HI;
         S_R_HI:  if (r_round == LAST_HI) w_next_state = S_R_FIN;
         S_R_FIN: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_cnt <= '0;
         r_round    <= '0;
         for (int i = 0; i < WORDS_PER_BLOCK; i++) r_win[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_win[0]   <= bus.data_in;
                  r_word_cnt <= 4'd1;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_win[r_word_cnt] <= bus.data_in;
                  r_word_cnt        <= r_word_cnt + 4'd1;
               end
            end
            S_R_LO, S_R_HI: begin
               for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) r_win[i] <= r_win[i+1];
               r_win[WORDS_PER_BLOCK-1] <= w_new;
               r_round                  <= r_round + 7'd1;
            end
            default: begin
               r_round    <= '0;
               r_word_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.ready_out     = 1'b0;
      bus.load_out      = 1'b0;
      bus.FSM_state_out = RS_IDLE;
      bus.round_out     = r_round;
      bus.w_out         = '0;
      bus.busy_out      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: bus.ready_out = 1'b1;
         S_LOAD: begin
            bus.ready_out = 1'b1;
            bus.load_out  = bus.valid_in && (r_word_cnt == LAST_WORD);
         end
         S_R_LO:  bus.FSM_state_out = RS_ROUND0TO15;
         S_R_HI:  bus.FSM_state_out = RS_ROUND16TO63;
         S_R_FIN: bus.FSM_state_out = RS_ROUND64;
         default: bus.FSM_state_out = RS_IDLE;
      endcase
      if (w_rounding) bus.w_out = r_win[0];
   end

endmodule

`default_nettype wire
